// File: rtl/uart_tx_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter and its round-robin picker.
package uart_tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        SEND   = 2'd2,
        DRAIN  = 2'd3
    } arb_state_t;

    localparam int NREQ_DEF = 4;
    localparam int DW_DEF   = 8;
    localparam int IDW      = $clog2(NREQ_DEF);

    // Reduces a sum below 2*n modulo n without a divider, so non-power-of-two n works.
    function automatic int wrap_idx(input int v, input int n);
        return (v >= n) ? v - n : v;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping upward.
module rr_picker
    import uart_tx_arb_pkg::*;
#(
    parameter int N  = NREQ_DEF,
    parameter int PW = IDW
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [PW-1:0] idx_o,
    output logic          any_o
);

    logic [PW-1:0] cand;

    // Scan farthest-first so the candidate closest to the pointer is the one left standing.
    always_comb begin
        idx_o = ptr_i;
        any_o = 1'b0;
        cand  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = PW'(wrap_idx(int'(ptr_i) + k, N));
            if (req_i[cand]) begin
                idx_o = cand;
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin sharing of one UART transmitter between NREQ byte sources.
// Optional send watchdog enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int NREQ           = NREQ_DEF,
    parameter int DW             = DW_DEF,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DW-1:0]       req_data,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          req_ready,
    output logic                     tx_send,
    output logic [DW-1:0]            tx_data,
    input  logic                     tx_done,
    output logic                     busy,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     err_timeout
);

    localparam int GW = $clog2(NREQ);

    arb_state_t    state_q;
    logic [GW-1:0] grant_q;
    logic [GW-1:0] ptr_q;
    logic          busy_q;
    logic          tx_send_q;
    logic [DW-1:0] tx_data_q;
    logic          last_q;

    logic [GW-1:0] win;
    logic          any_req;
    logic [GW-1:0] ptr_d;
    logic          accept;
    logic [DW-1:0] lane_data [NREQ];

    rr_picker #(.N(NREQ), .PW(GW)) u_pick (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .idx_o (win),
        .any_o (any_req)
    );

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            lane_data[i] = req_data[i*DW +: DW];
        end
    end

    assign ptr_d  = (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + GW'(1);
    assign accept = (state_q == ACCEPT) && req_valid[grant_q] && tx_done;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_q] = 1'b1;
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q;
    logic          err_q;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ptr_q     <= '0;
            busy_q    <= 1'b0;
            tx_send_q <= 1'b0;
            tx_data_q <= '0;
            last_q    <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            cnt_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        grant_q <= win;
                        busy_q  <= 1'b1;
                        state_q <= ACCEPT;
                    end
                end
                ACCEPT: begin
                    if (accept) begin
                        tx_data_q <= lane_data[grant_q];
                        last_q    <= req_last[grant_q];
                        tx_send_q <= 1'b1;
                        state_q   <= SEND;
`ifdef UART_TX_ARB_TIMEOUT_EN
                        cnt_q     <= '0;
`endif
                    end
                end
                SEND: begin
                    if (!tx_done) begin
                        tx_send_q <= 1'b0;
                        state_q   <= DRAIN;
                    end
`ifdef UART_TX_ARB_TIMEOUT_EN
                    // Transmitter never went busy: abandon the packet and move past this owner.
                    else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                        tx_send_q <= 1'b0;
                        err_q     <= 1'b1;
                        ptr_q     <= ptr_d;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
`endif
                end
                DRAIN: begin
                    if (tx_done) begin
                        if (last_q) begin
                            ptr_q   <= ptr_d;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            state_q <= ACCEPT;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_send  = tx_send_q;
    assign tx_data  = tx_data_q;
    assign busy     = busy_q;
    assign grant_id = grant_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed tables, corner sequences and a random packet mix.
module tb_uart_tx_arbiter;
    localparam int NREQ = 4;
    localparam int DW   = 8;

    typedef struct {
        logic [7:0] d;
        bit         last;
        int         gap;
    } byte_t;

    typedef struct {
        logic [3:0]  mask;
        int          n;
        logic [15:0] order;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic [NREQ-1:0]   req_last = '0;
    logic [NREQ-1:0]   req_ready;
    logic              tx_send;
    logic [DW-1:0]     tx_data;
    logic              tx_done;
    logic              busy;
    logic [1:0]        grant_id;
    logic              err_timeout;

    uart_tx_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .tx_send    (tx_send),
        .tx_data    (tx_data),
        .tx_done    (tx_done),
        .busy       (busy),
        .grant_id   (grant_id),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int    total = 0;
    int    bad = 0;
    int    viol = 0;
    int    send_rises = 0;
    bit    prev_send = 1'b0;
    bit    rst_req = 1'b0;
    int    model_ptr = 0;
    byte_t rq [NREQ][$];
    int    gapcnt [NREQ];
    int    acc_cnt [NREQ];
    int    txlog[$];
    int    expq[$];

    // Transmitter model: latches a byte on send while idle, then reports busy for a hold time.
    logic mbusy = 1'b0;
    int   mcnt = 0;
    int   hold_min = 3;
    int   hold_rng = 0;
    bit   stuck = 1'b0;
    assign tx_done = ~mbusy;

    always @(posedge clk) begin
        if (!mbusy) begin
            if (tx_send && !stuck) begin
                mbusy <= 1'b1;
                mcnt  <= hold_min + int'($urandom_range(hold_rng));
                txlog.push_back(int'(grant_id) * 256 + int'(tx_data));
            end
        end else if (mcnt <= 1) begin
            mbusy <= 1'b0;
        end else begin
            mcnt <= mcnt - 1;
        end
    end

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(negedge clk);
        rst_n = ~rst_req;
        for (int i = 0; i < NREQ; i++) begin
            logic v;
            v = 1'b0;
            if (rq[i].size() > 0) begin
                if (gapcnt[i] > 0) gapcnt[i]--;
                else v = 1'b1;
            end
            req_valid[i] = v;
            req_data[i*DW +: DW] = v ? rq[i][0].d : 8'($urandom);
            req_last[i] = v ? rq[i][0].last : 1'($urandom);
        end
        #4;
        if (req_ready != '0 && req_ready != (NREQ'(1) << grant_id)) viol++;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                if (!req_valid[i] || !tx_done) viol++;
                acc_cnt[i]++;
                if (rq[i].size() > 0) begin
                    void'(rq[i].pop_front());
                    gapcnt[i] = (rq[i].size() > 0) ? rq[i][0].gap : 0;
                end
            end
        end
        if (tx_send && !prev_send) send_rises++;
        prev_send = tx_send;
`ifndef UART_TX_ARB_TIMEOUT_EN
        if (err_timeout) viol++;
`endif
    endtask

    function automatic bit pending();
        for (int i = 0; i < NREQ; i++) if (rq[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic push_byte(input int r, input logic [7:0] d, input bit last, input int gap);
        byte_t b;
        b.d = d; b.last = last; b.gap = gap;
        rq[r].push_back(b);
    endtask

    // Reference: whole packets in round-robin order over requesters that still have data.
    task automatic build_expected();
        byte_t tq [NREQ][$];
        byte_t b;
        int    j;
        bit    found;
        for (int i = 0; i < NREQ; i++) tq[i] = rq[i];
        forever begin
            found = 1'b0;
            j = 0;
            for (int k = 0; k < NREQ; k++) begin
                if (!found && tq[(model_ptr + k) % NREQ].size() > 0) begin
                    found = 1'b1;
                    j = (model_ptr + k) % NREQ;
                end
            end
            if (!found) break;
            do begin
                b = tq[j].pop_front();
                expq.push_back(j * 256 + int'(b.d));
            end while (!b.last);
            model_ptr = (j + 1) % NREQ;
        end
    endtask

    task automatic run_until_done(input string name, input int budget);
        int c = 0;
        step();
        while ((pending() || busy || mbusy) && c < budget) begin
            step();
            c++;
        end
        if (c >= budget) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: still busy after %0d cycles, expected idle", name, c);
        end
    endtask

    task automatic compare_log(input string name);
        int first = -1;
        total++;
        for (int k = 0; k < txlog.size() && k < expq.size(); k++)
            if (first < 0 && txlog[k] != expq[k]) first = k;
        if (first >= 0 || txlog.size() != expq.size()) begin
            bad++;
            if (first < 0) first = (txlog.size() < expq.size()) ? txlog.size() : expq.size();
            $display("FAIL %s: got %0d bytes (item %0d = 0x%0h), expected %0d bytes (item %0d = 0x%0h)",
                     name, txlog.size(), first, (first < txlog.size()) ? txlog[first] : -1,
                     expq.size(), first, (first < expq.size()) ? expq[first] : -1);
        end
        txlog.delete();
        expq.delete();
    endtask

    task automatic do_reset();
        int c = 0;
        rst_req = 1'b1;
        step();
        step();
        rst_req = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            rq[i].delete();
            gapcnt[i] = 0;
        end
        while (mbusy && c < 200) begin
            step();
            c++;
        end
        step();
        model_ptr = 0;
        txlog.delete();
        expq.delete();
    endtask

    vec_t vt [6];

    initial begin
        int c;
        int stallbad;
        vt[0] = '{4'b0001, 1, 16'h0000};
        vt[1] = '{4'b0110, 2, 16'h0021};
        vt[2] = '{4'b1111, 4, 16'h2103};
        vt[3] = '{4'b0101, 2, 16'h0020};
        vt[4] = '{4'b1000, 1, 16'h0003};
        vt[5] = '{4'b1010, 2, 16'h0031};
        for (int i = 0; i < NREQ; i++) begin
            gapcnt[i] = 0;
            acc_cnt[i] = 0;
        end

        // Reset values with a requester pushing during reset.
        rst_req = 1'b1;
        push_byte(0, 8'h99, 1'b1, 0);
        step(); step(); step();
        check("rst_tx_send", int'(tx_send), 0);
        check("rst_tx_data", int'(tx_data), 0);
        check("rst_req_ready", int'(req_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_grant_id", int'(grant_id), 0);
        check("rst_err_timeout", int'(err_timeout), 0);
        do_reset();

        // Table: 1-byte packets for each requester in mask, with hand-derived grant order.
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < NREQ; i++)
                if (vt[e].mask[i]) push_byte(i, 8'(16 * e + i), 1'b1, 0);
            for (int k = 0; k < vt[e].n; k++) begin
                logic [15:0] ord;
                int r;
                ord = vt[e].order;
                r = int'(ord[4*k +: 4]);
                expq.push_back(r * 256 + 16 * e + r);
            end
            run_until_done($sformatf("table%0d", e), 400);
            compare_log($sformatf("table%0d_order", e));
        end

        // Single 3-byte packet, transmitter busy 10 cycles per byte.
        do_reset();
        hold_min = 10; hold_rng = 0;
        send_rises = 0;
        push_byte(0, 8'h41, 1'b0, 0);
        push_byte(0, 8'h42, 1'b0, 0);
        push_byte(0, 8'h43, 1'b1, 0);
        expq.push_back(16'h041); expq.push_back(16'h042); expq.push_back(16'h043);
        run_until_done("pkt3", 400);
        compare_log("pkt3_data");
        check("pkt3_send_pulses", send_rises, 3);
        check("pkt3_busy_end", int'(busy), 0);
        push_byte(0, 8'h01, 1'b1, 0);
        push_byte(1, 8'h02, 1'b1, 0);
        expq.push_back(16'h102); expq.push_back(16'h001);
        run_until_done("ptr1", 400);
        compare_log("ptr_after_pkt3");

        // Owner stalls 20 cycles mid-packet while requester 3 waits.
        do_reset();
        hold_min = 3;
        push_byte(0, 8'h51, 1'b0, 0);
        push_byte(0, 8'h52, 1'b1, 20);
        push_byte(3, 8'h5F, 1'b1, 0);
        c = 0;
        while (rq[0].size() != 1 && c < 50) begin step(); c++; end
        check("stall_first_accept", int'(rq[0].size()), 1);
        stallbad = 0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (grant_id != 2'd0 || req_ready[3] || !busy) stallbad++;
        end
        check("stall_lock_held", stallbad, 0);
        expq.push_back(16'h051); expq.push_back(16'h052); expq.push_back(16'h35F);
        run_until_done("stall", 400);
        compare_log("stall_order");

        // Reset during SEND abandons the packet and clears the pointer.
        do_reset();
        push_byte(0, 8'h70, 1'b1, 0);
        run_until_done("pre_rst", 400);
        txlog.delete();
        push_byte(2, 8'h77, 1'b1, 0);
        c = 0;
        while (!tx_send && c < 50) begin step(); c++; end
        check("rst_mid_send_seen", int'(tx_send), 1);
        rst_req = 1'b1;
        step();
        step();
        check("rst_mid_tx_send", int'(tx_send), 0);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_grant", int'(grant_id), 0);
        do_reset();
        push_byte(0, 8'h01, 1'b1, 0);
        push_byte(1, 8'h02, 1'b1, 0);
        expq.push_back(16'h001); expq.push_back(16'h102);
        run_until_done("post_rst", 400);
        compare_log("rst_mid_ptr");

        // All requesters valid with 1-byte packets.
        do_reset();
        push_byte(0, 8'hA0, 1'b1, 0);
        push_byte(0, 8'hA4, 1'b1, 0);
        push_byte(1, 8'hA1, 1'b1, 0);
        push_byte(2, 8'hA2, 1'b1, 0);
        push_byte(3, 8'hA3, 1'b1, 0);
        expq.push_back(16'h0A0); expq.push_back(16'h1A1); expq.push_back(16'h2A2);
        expq.push_back(16'h3A3); expq.push_back(16'h0A4);
        run_until_done("all4", 400);
        compare_log("all4_order");

        // Random packet mixes against the reference model.
        do_reset();
        for (int r = 0; r < 6; r++) begin
            hold_min = 1 + int'($urandom_range(2));
            hold_rng = int'($urandom_range(3));
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(3) != 0) begin
                    int npk;
                    npk = 1 + int'($urandom_range(1));
                    for (int p = 0; p < npk; p++) begin
                        int nb;
                        nb = 1 + int'($urandom_range(3));
                        for (int b = 0; b < nb; b++)
                            push_byte(i, 8'($urandom), b == nb - 1,
                                      (b == 0) ? 0 : int'($urandom_range(2)));
                    end
                end
            end
            build_expected();
            run_until_done($sformatf("rand%0d", r), 3000);
            compare_log($sformatf("rand%0d_order", r));
        end

`ifdef UART_TX_ARB_TIMEOUT_EN
        // Transmitter never leaves idle: watchdog fires after 16 SEND cycles.
        do_reset();
        hold_min = 3; hold_rng = 0;
        stuck = 1'b1;
        push_byte(0, 8'h61, 1'b1, 0);
        push_byte(1, 8'h62, 1'b1, 0);
        c = 0;
        while (!tx_send && c < 50) begin step(); c++; end
        for (int k = 0; k < 15; k++) step();
        check("to_err_before", int'(err_timeout), 0);
        check("to_send_before", int'(tx_send), 1);
        step();
        check("to_err_after", int'(err_timeout), 1);
        check("to_send_after", int'(tx_send), 0);
        check("to_busy_after", int'(busy), 0);
        step();
        step();
        check("to_next_grant", int'(grant_id), 1);
        stuck = 1'b0;
        expq.push_back(16'h162);
        run_until_done("to_rest", 400);
        compare_log("to_rest_order");
        check("to_err_sticky", int'(err_timeout), 1);
`endif

        check("protocol_violations", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
